// File: rtl/bcd_conv_arbiter_if.sv
// Request/response bus between the requesters and the shared BCD converter arbiter.
// The master side issues requests; the slave side (the arbiter) accepts and responds.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [19:0]           resp_bcd;
    logic                  resp_neg;
    logic                  resp_sat;
    logic                  resp_err;

    modport master (
        output req_valid, req_data,
        input  req_ready, resp_valid, resp_bcd, resp_neg, resp_sat, resp_err
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, resp_valid, resp_bcd, resp_neg, resp_sat, resp_err
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD converter between NUM_REQ requesters,
// with sign/magnitude pre-processing and a watchdog that resets a hung converter.
module bcd_conv_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int RST_CYC     = 2
) (
    input  logic                clk,
    input  logic                reset,
    bcd_conv_arbiter_if.slave   bus,
    output logic                busy,
    output logic                conv_inicio,
    output logic [14:0]         conv_bin,
    output logic                conv_rst,
    input  logic                conv_done,
    input  logic [19:0]         conv_bcd
);
    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RECOVER, S_RESP} state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [RC_W-1:0]    rc_cnt_q, rc_cnt_d;
    logic [14:0]        conv_bin_q, conv_bin_d;
    logic               neg_q, neg_d, sat_q, sat_d;
    logic [19:0]        resp_bcd_q, resp_bcd_d;
    logic               resp_neg_q, resp_neg_d, resp_sat_q, resp_sat_d, resp_err_q, resp_err_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
    logic               busy_q, busy_d, conv_inicio_q, conv_inicio_d, conv_rst_q, conv_rst_d;

    logic               found_s;
    logic [PTR_W-1:0]   pick_s, rr_next_s;
    logic [15:0]        sel_data_s, mag_s;
    logic               sat_s;
    logic [14:0]        bin_s;

    // Round-robin pick of the first valid requester at or after rr_ptr, plus sign/magnitude of its data.
    always_comb begin
        int idx;
        idx     = 0;
        found_s = 1'b0;
        pick_s  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx     = int'(rr_ptr_q) + i;
            idx     = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            pick_s  = bus.req_valid[idx] ? PTR_W'(idx) : pick_s;
            found_s = found_s | bus.req_valid[idx];
        end
        rr_next_s  = (pick_s == PTR_W'(NUM_REQ - 1)) ? '0 : pick_s + PTR_W'(1);
        sel_data_s = bus.req_data[int'(pick_s)*16 +: 16];
        mag_s      = sel_data_s[15] ? (16'd0 - sel_data_s) : sel_data_s;
        // -32768 has no positive 16-bit twin; clamp it to the largest magnitude.
        sat_s      = (sel_data_s == 16'h8000);
        bin_s      = sat_s ? 15'h7FFF : mag_s[14:0];
    end

    // Next-state and registered-output logic; single-cycle pulses default low.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        wd_cnt_d      = wd_cnt_q;
        rc_cnt_d      = rc_cnt_q;
        conv_bin_d    = conv_bin_q;
        neg_d         = neg_q;
        sat_d         = sat_q;
        resp_bcd_d    = resp_bcd_q;
        resp_neg_d    = resp_neg_q;
        resp_sat_d    = resp_sat_q;
        resp_err_d    = resp_err_q;
        req_ready_d   = '0;
        resp_valid_d  = '0;
        conv_inicio_d = 1'b0;
        conv_rst_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d       = S_ISSUE;
                    grant_d       = pick_s;
                    rr_ptr_d      = rr_next_s;
                    conv_bin_d    = bin_s;
                    neg_d         = sel_data_s[15];
                    sat_d         = sat_s;
                    req_ready_d   = onehot(pick_s);
                    conv_inicio_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_d  = S_WAIT;
                wd_cnt_d = '0;
            end
            S_WAIT: begin
                if (conv_done) begin
                    state_d      = S_RESP;
                    resp_bcd_d   = conv_bcd;
                    resp_neg_d   = neg_q;
                    resp_sat_d   = sat_q;
                    resp_err_d   = 1'b0;
                    resp_valid_d = onehot(grant_q);
                end else if (wd_cnt_q == WD_W'(TIMEOUT_CYC)) begin
                    state_d    = S_RECOVER;
                    rc_cnt_d   = '0;
                    conv_rst_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
            end
            S_RECOVER: begin
                if (rc_cnt_q == RC_W'(RST_CYC - 1)) begin
                    state_d      = S_RESP;
                    resp_bcd_d   = 20'd0;
                    resp_neg_d   = 1'b0;
                    resp_sat_d   = 1'b0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = onehot(grant_q);
                end else begin
                    rc_cnt_d   = rc_cnt_q + RC_W'(1);
                    conv_rst_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            wd_cnt_q      <= '0;
            rc_cnt_q      <= '0;
            conv_bin_q    <= 15'd0;
            neg_q         <= 1'b0;
            sat_q         <= 1'b0;
            resp_bcd_q    <= 20'd0;
            resp_neg_q    <= 1'b0;
            resp_sat_q    <= 1'b0;
            resp_err_q    <= 1'b0;
            req_ready_q   <= '0;
            resp_valid_q  <= '0;
            busy_q        <= 1'b0;
            conv_inicio_q <= 1'b0;
            conv_rst_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            wd_cnt_q      <= wd_cnt_d;
            rc_cnt_q      <= rc_cnt_d;
            conv_bin_q    <= conv_bin_d;
            neg_q         <= neg_d;
            sat_q         <= sat_d;
            resp_bcd_q    <= resp_bcd_d;
            resp_neg_q    <= resp_neg_d;
            resp_sat_q    <= resp_sat_d;
            resp_err_q    <= resp_err_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            busy_q        <= busy_d;
            conv_inicio_q <= conv_inicio_d;
            conv_rst_q    <= conv_rst_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_bcd   = resp_bcd_q;
    assign bus.resp_neg   = resp_neg_q;
    assign bus.resp_sat   = resp_sat_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = busy_q;
    assign conv_inicio    = conv_inicio_q;
    assign conv_bin       = conv_bin_q;
    assign conv_rst       = conv_rst_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: two randomized requesters, a behavioural
// converter model, and a monitor that checks every grant and response against expectations.
module tb_bcd_conv_arbiter;
    localparam int NUM_REQ = 2;
    localparam int RST_CYC = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
    logic        busy, conv_inicio, conv_rst, conv_done;
    logic [14:0] conv_bin;
    logic [19:0] conv_bcd;
    logic        v0, v1;
    logic [15:0] d0, d1;

    assign bus.req_valid = {v1, v0};
    assign bus.req_data  = {d1, d0};

    bcd_conv_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(255), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .reset(rst_n), .bus(bus), .busy(busy),
        .conv_inicio(conv_inicio), .conv_bin(conv_bin), .conv_rst(conv_rst),
        .conv_done(conv_done), .conv_bcd(conv_bcd)
    );

    typedef struct {
        int          id;
        logic [19:0] bcd;
        logic        neg, sat, err;
        logic [14:0] mag;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sq0[$], sq1[$];
    int          checks = 0, errors = 0;
    int          gap_max = 3, lat_fixed = 0, cyc = 0;
    bit          dead_mode = 1'b0;
    logic [1:0]  vld_edge = 2'b00;

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int x;
        r = 20'd0;
        x = v;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input int id, input logic [15:0] d, input bit dead);
        exp_t e;
        int v, m;
        v = int'($signed(d));
        m = (v < 0) ? -v : v;
        e.id  = id;
        e.neg = (v < 0);
        e.sat = (m == 32768);
        if (e.sat) m = 32767;
        e.mag = 15'(m);
        e.bcd = to_bcd(m);
        e.err = 1'b0;
        if (dead) begin
            e.bcd = 20'd0; e.neg = 1'b0; e.sat = 1'b0; e.err = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic int find_id(input int id);
        for (int k = 0; k < sb.size(); k++)
            if (sb[k].id == id) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        vld_edge <= bus.req_valid;
    end

    // Requester 0: hold valid/data until req_ready, then an optional idle gap.
    initial begin : drv0
        int wt, gap;
        v0 = 1'b0; d0 = 16'd0; wt = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (v0) begin
                if (bus.req_ready[0]) begin
                    v0 = 1'b0; gap = $urandom_range(0, gap_max);
                end else if (++wt > 3000) begin
                    checks++; errors++; v0 = 1'b0;
                    $display("FAIL req0_ready_timeout waited=%0d limit=3000", wt);
                end
            end else if (gap > 0) begin
                gap--;
            end else if (sq0.size() > 0) begin
                d0 = sq0.pop_front(); v0 = 1'b1; wt = 0;
                sb.push_back(model(0, d0, dead_mode));
            end
        end
    end

    // Requester 1.
    initial begin : drv1
        int wt, gap;
        v1 = 1'b0; d1 = 16'd0; wt = 0; gap = 0;
        forever begin
            @(negedge clk);
            if (v1) begin
                if (bus.req_ready[1]) begin
                    v1 = 1'b0; gap = $urandom_range(0, gap_max);
                end else if (++wt > 3000) begin
                    checks++; errors++; v1 = 1'b0;
                    $display("FAIL req1_ready_timeout waited=%0d limit=3000", wt);
                end
            end else if (gap > 0) begin
                gap--;
            end else if (sq1.size() > 0) begin
                d1 = sq1.pop_front(); v1 = 1'b1; wt = 0;
                sb.push_back(model(1, d1, dead_mode));
            end
        end
    end

    // Converter model: done after a random latency with the BCD of conv_bin; garbage on conv_bcd otherwise.
    initial begin : conv_model
        bit pend;
        int cnt;
        logic [19:0] pbcd;
        conv_done = 1'b0; conv_bcd = 20'd0; pend = 1'b0; cnt = 0; pbcd = 20'd0;
        forever begin
            @(negedge clk);
            conv_done = 1'b0;
            conv_bcd  = 20'($urandom);
            if (conv_rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    conv_done = 1'b1; conv_bcd = pbcd; pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (conv_inicio && !dead_mode) begin
                pend = 1'b1;
                cnt  = (lat_fixed > 0) ? lat_fixed : $urandom_range(0, 12);
                pbcd = to_bcd(int'(conv_bin));
            end
        end
    end

    // Monitor: grants, conv_bin, round-robin order, responses, recovery timing.
    initial begin : monitor
        int last_g, t_issue, rst_run, idx;
        last_g = -1; t_issue = 0; rst_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_g = -1; rst_run = 0;
                continue;
            end
            for (int g = 0; g < NUM_REQ; g++) begin
                if (bus.req_ready[g]) begin
                    chk($sformatf("grant%0d_was_valid", g), 32'(vld_edge[g]), 32'd1);
                    if (vld_edge[1-g]) chk($sformatf("rr_alternate_g%0d", g), 32'(last_g != g), 32'd1);
                    last_g = g;
                    chk("inicio_with_ready", 32'(conv_inicio), 32'd1);
                    idx = find_id(g);
                    if (idx < 0) begin
                        checks++; errors++;
                        $display("FAIL grant_no_request requester=%0d", g);
                    end else begin
                        chk($sformatf("conv_bin_r%0d", g), 32'(conv_bin), 32'(sb[idx].mag));
                    end
                    t_issue = cyc;
                end
                if (bus.resp_valid[g]) begin
                    idx = find_id(g);
                    if (idx < 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_resp requester=%0d bcd=%0h", g, bus.resp_bcd);
                    end else begin
                        chk($sformatf("resp_bcd_r%0d", g), 32'(bus.resp_bcd), 32'(sb[idx].bcd));
                        chk($sformatf("resp_neg_sat_err_r%0d", g),
                            32'({bus.resp_neg, bus.resp_sat, bus.resp_err}),
                            32'({sb[idx].neg, sb[idx].sat, sb[idx].err}));
                        sb.delete(idx);
                    end
                end
            end
            if (conv_inicio) chk("ready_count_at_inicio", 32'($countones(bus.req_ready)), 32'd1);
            if (conv_rst) begin
                if (rst_run == 0)
                    chk("timeout_distance_in_256_258",
                        32'((cyc - t_issue) >= 256 && (cyc - t_issue) <= 258), 32'd1);
                rst_run++;
            end else if (rst_run > 0) begin
                chk("conv_rst_width", 32'(rst_run), 32'(RST_CYC));
                rst_run = 0;
            end
        end
    end

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((sq0.size() + sq1.size() + sb.size()) != 0 || v0 || v1 || busy) begin
            @(negedge clk);
            if (++n > budget) begin
                checks++; errors++;
                $display("FAIL drain_timeout pending=%0d limit=%0d", sb.size(), budget);
                sq0.delete(); sq1.delete(); sb.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_bcd", 32'(bus.resp_bcd), 32'd0);
        chk("rst_flags", 32'({bus.resp_neg, bus.resp_sat, bus.resp_err}), 32'd0);
        chk("rst_conv_outs", 32'({conv_inicio, conv_rst, conv_bin}), 32'd0);
        rst_n = 1'b1;

        sq0.push_back(16'd12345); drain(200);
        sq1.push_back(16'hFC19);  drain(200);
        sq0.push_back(16'h8000);  drain(200);
        sq1.push_back(16'h0000); sq0.push_back(16'h7FFF); sq1.push_back(16'hFFFF);
        drain(400);

        gap_max = 0;
        for (int i = 0; i < 8; i++) begin
            sq0.push_back(rand_val());
            sq1.push_back(rand_val());
        end
        drain(1000);
        gap_max = 3;

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 0) sq0.push_back(rand_val());
            else                           sq1.push_back(rand_val());
        end
        drain(3000);

        dead_mode = 1'b1;
        sq1.push_back(16'd4321);
        drain(1000);
        dead_mode = 1'b0;
        sq0.push_back(16'd42);
        drain(200);

        lat_fixed = 30;
        sq0.push_back(16'd777);
        n = 0;
        while (!conv_inicio && n < 100) begin
            @(negedge clk); n++;
        end
        chk("midrst_issue_seen", 32'(conv_inicio), 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_conv_rst", 32'(conv_rst), 32'd0);
        chk("midrst_resp_bcd", 32'(bus.resp_bcd), 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst_busy_after_stray_done", 32'(busy), 32'd0);
        lat_fixed = 0;
        sq1.push_back(16'hFFFB);
        drain(200);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "bench did not finish");
    end
endmodule
